synth_sequencer: RTL and testbench
==================================

SYNTH_SEQUENCER -- requirements
Module: synth_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: event FIFO depth; power of two.
REQ-002 Parameter TICK_DIV, default 48000: clk cycles per tick (1 ms at 48 MHz).
REQ-003 Parameter TIMEOUT, default 255: max clk cycles m_wen waits for m_ready.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 ev_data  input  56  event: [15:0] delay in ticks, [23:16] synth register address, [55:24] write data.
REQ-007 ev_valid  input  1  event push request.
REQ-008 ev_ready  output  1  FIFO can accept; push occurs when ev_valid && ev_ready.
REQ-009 run  input  1  playback enable.
REQ-010 flush  input  1  discard all queued events.
REQ-011 m_addr  output  8  synth register-bus address.
REQ-012 m_data  output  32  synth register-bus write data.
REQ-013 m_wen  output  1  synth register-bus write strobe.
REQ-014 m_ready  input  1  write-accept from the synth register bus.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 err_timeout  output  1  sticky; set on write timeout.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, WAIT and WRITE.
REQ-019 IDLE->LOAD when run=1 and count>0; LOAD pops the head into delay/addr/data registers, clears the prescaler and goes to WAIT in one cycle.
REQ-020 WAIT SHALL decrement the delay each time the prescaler reaches TICK_DIV-1 and wraps; with delay d, WRITE is entered exactly d*TICK_DIV cycles after LOAD, or the cycle after LOAD if d=0.
REQ-021 When run=0 in WAIT, the prescaler and delay SHALL freeze and resume unchanged once run returns to 1.
REQ-022 WRITE SHALL drive m_addr, m_data and m_wen=1 until m_ready=1 is sampled, then drop m_wen the next cycle and return to IDLE.
REQ-023 m_ready SHALL be ignored while m_wen=0; m_addr and m_data SHALL be stable for the whole strobe.
REQ-024 If m_ready is not seen within TIMEOUT cycles of m_wen rising, the block SHALL drop m_wen, set err_timeout, and return to IDLE; err_timeout clears only on reset.
REQ-025 ev_ready = (count<DEPTH) && !flush; a push while full SHALL be dropped.
REQ-026 A push and a LOAD pop in the same cycle SHALL both occur and leave count unchanged; at full, only the pop occurs.
REQ-027 flush SHALL zero count and pointers in one cycle and force WAIT->IDLE; a WRITE in progress SHALL complete normally.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-029 Run dropping during WRITE SHALL NOT abort the write.

Reset
REQ-030 While rst=0 at posedge clk: state=IDLE, count=0, pointers=0, prescaler=0, m_wen=0, m_addr=0, m_data=0, busy=0, err_timeout=0; FIFO contents are don't-care.
REQ-031 Reset asserted mid-WRITE SHALL drop m_wen on the next edge.

Configuration
REQ-032 Macro SYNTH_SEQUENCER_LOOP_EN, when defined, adds input loop (1 bit).
REQ-033 With the macro and loop=1, each event SHALL be re-pushed to the FIFO tail in the cycle its write completes or times out; ev_ready SHALL be forced 0, so the queue replays forever.
REQ-034 Without the macro, no loop port exists and events are consumed once.

Verification (TICK_DIV=4, TIMEOUT=8, DEPTH=4)
REQ-035 Push {delay=3, addr=0x10, data=0x0001_0C00}, run=1, m_ready one cycle after m_wen -> m_wen rises 12 cycles after LOAD, is high 2 cycles, addr 0x10 and data stable.
REQ-036 Push 5 events with run=0 -> 4 accepted, ev_ready=0 at count=4, 5th dropped, count=4.
REQ-037 Hold m_ready=0 -> m_wen drops after 8 cycles, err_timeout=1, next event proceeds.
REQ-038 Delay=10, run=0 after 2 ticks for 20 cycles -> m_wen rises 20 cycles later than uninterrupted.
REQ-039 flush during WAIT with 3 queued -> count=0, state IDLE, no m_wen; flush during WRITE -> write completes.
REQ-040 LOOP_EN, 2 events, loop=1 -> writes alternate A,B,A,B; count stays 2.

Source files
------------

// File: rtl/synth_sequencer.sv
// Timed write sequencer: queued events wait a tick-based delay, then issue one register-bus write.
// Optional replay mode is enabled by defining SYNTH_SEQUENCER_LOOP_EN (adds the loop input).
module synth_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 48000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [55:0]            ev_data,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic                   run,
  input  logic                   flush,
`ifdef SYNTH_SEQUENCER_LOOP_EN
  input  logic                   loop,
`endif
  output logic [7:0]             m_addr,
  output logic [31:0]            m_data,
  output logic                   m_wen,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_timeout
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StWrite} state_e;

  state_e            state_q;
  logic [55:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [PreW-1:0]   pre_q;
  logic [15:0]       dly_q;
  logic [55:0]       ev_q;
  logic [ToW-1:0]    timer_q;
  logic              m_wen_q, err_q;
  logic [7:0]        m_addr_q;
  logic [31:0]       m_data_q;

  logic        loop_en;
  logic [55:0] head;
  logic        push_ext, push_loop, push, pop, write_done, not_full;
  logic [55:0] push_word;

`ifdef SYNTH_SEQUENCER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign head       = mem_q[rd_ptr_q];
  assign not_full   = count_q < CntW'(DEPTH);
  assign ev_ready   = not_full && !flush && !loop_en;
  assign push_ext   = ev_valid && ev_ready;
  assign pop        = (state_q == StLoad) && !flush && (count_q != '0);
  assign write_done = (state_q == StWrite) && (m_ready || timer_q == ToW'(TIMEOUT - 1));
  // Replay re-queues the original event word, not the decremented delay.
  assign push_loop  = write_done && loop_en && !flush && not_full;
  assign push       = push_ext || push_loop;
  assign push_word  = push_loop ? ev_q : ev_data;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
      dly_q    <= '0;
      ev_q     <= '0;
      timer_q  <= '0;
      m_wen_q  <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (run && count_q != '0 && !flush) state_q <= StLoad;
        end
        StLoad: begin
          if (!pop) begin
            state_q <= StIdle;
          end else begin
            ev_q  <= head;
            dly_q <= head[15:0];
            pre_q <= '0;
            if (head[15:0] == 16'd0) begin
              state_q  <= StWrite;
              m_wen_q  <= 1'b1;
              m_addr_q <= head[23:16];
              m_data_q <= head[55:24];
              timer_q  <= '0;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (run) begin
            if (pre_q == PreW'(TICK_DIV - 1)) begin
              pre_q <= '0;
              dly_q <= dly_q - 16'd1;
            end else begin
              pre_q <= pre_q + PreW'(1);
            end
            // Leave one cycle before the last tick so WRITE lands exactly delay*TICK_DIV after LOAD.
            if (dly_q == 16'd1 && pre_q == PreW'(TICK_DIV - 2)) begin
              state_q  <= StWrite;
              m_wen_q  <= 1'b1;
              m_addr_q <= ev_q[23:16];
              m_data_q <= ev_q[55:24];
              timer_q  <= '0;
            end
          end
        end
        StWrite: begin
          if (m_ready) begin
            m_wen_q <= 1'b0;
            state_q <= StIdle;
          end else if (timer_q == ToW'(TIMEOUT - 1)) begin
            m_wen_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + ToW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_addr      = m_addr_q;
  assign m_data      = m_data_q;
  assign m_wen       = m_wen_q;
  assign busy        = state_q != StIdle;
  assign count       = count_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_synth_sequencer.sv
// Self-checking bench for synth_sequencer (DEPTH=4, TICK_DIV=4, TIMEOUT=8).
// Timing expectations come from delay*TICK_DIV arithmetic and a queue of pushed events.
module tb_synth_sequencer;
  localparam int DEPTH  = 4;
  localparam int TICK   = 4;
  localparam int TO     = 8;
  localparam int BUDGET = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [55:0] ev_data = '0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic        m_wen;
  logic        m_ready = 1'b0;
  logic        busy;
  logic [2:0]  count;
  logic        err_timeout;
`ifdef SYNTH_SEQUENCER_LOOP_EN
  logic        loop = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  bit          err_exp = 1'b0;
  logic [55:0] model_q[$];

  always #5 clk = ~clk;

  synth_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_data     (ev_data),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .run         (run),
    .flush       (flush),
`ifdef SYNTH_SEQUENCER_LOOP_EN
    .loop        (loop),
`endif
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_wen       (m_wen),
    .m_ready     (m_ready),
    .busy        (busy),
    .count       (count),
    .err_timeout (err_timeout)
  );

  function automatic logic [55:0] mk(input logic [15:0] dl, input logic [7:0] ad,
                                     input logic [31:0] da);
    return {da, ad, dl};
  endfunction

  task automatic push_event(input logic [55:0] w);
    ev_data  = w;
    ev_valid = 1'b1;
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  // Waits for LOAD, then the strobe; acks `ack` cycles into the strobe (never if >= TO).
  // Optionally drops run for p_len cycles starting p_at cycles after LOAD.
  task automatic observe(input int ack, input int p_at, input int p_len,
                         output int lat, output int len, output logic [7:0] a,
                         output logic [31:0] d, output bit stable, output bit to);
    int n;
    lat = 0; len = 0; a = '0; d = '0; stable = 1'b1; to = 1'b0; n = 0;
    while (!busy) begin
      if (n >= BUDGET) begin to = 1'b1; return; end
      @(negedge clk); n++;
    end
    while (!m_wen) begin
      if (lat >= BUDGET) begin to = 1'b1; return; end
      if (p_len > 0) run = !(lat >= p_at && lat < p_at + p_len);
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk); lat++;
    end
    if (p_len > 0) run = 1'b1;
    a = m_addr; d = m_data;
    while (m_wen) begin
      if (len >= BUDGET) begin to = 1'b1; m_ready = 1'b0; return; end
      if (m_addr !== a || m_data !== d) stable = 1'b0;
      m_ready = (len == ack);
      @(negedge clk); len++;
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; ev_valid = 1'b1; ev_data = {24'($urandom), $urandom};
    repeat (3) @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({m_wen, busy, err_timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {m_wen, busy, err_timeout}); end
    checks++; if ({m_addr, m_data} !== 40'd0) begin
      errors++; $display("FAIL reset_bus got %h want 0", {m_addr, m_data}); end
    ev_valid = 1'b0; run = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat, len; logic [7:0] a; logic [31:0] d; bit st, to;
    push_event(mk(16'd3, 8'h10, 32'h0001_0C00));
    run = 1'b1;
    observe(1, 0, 0, lat, len, a, d, st, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got stuck want strobe"); end
    checks++; if (lat != 12) begin errors++; $display("FAIL basic_lat got %0d want 12", lat); end
    checks++; if (len != 2) begin errors++; $display("FAIL basic_len got %0d want 2", len); end
    checks++; if (a !== 8'h10 || d !== 32'h0001_0C00) begin
      errors++; $display("FAIL basic_bus got %h/%h want 10/00010c00", a, d); end
    checks++; if (!st) begin errors++; $display("FAIL basic_stable got unstable want stable"); end
    run = 1'b0;
  endtask

  task automatic test_full();
    logic [55:0] w; int lat, len; logic [7:0] a; logic [31:0] d; bit st, to;
    model_q.delete();
    for (int i = 0; i < 5; i++) begin
      w = mk(16'd0, 8'(8'h20 + i), $urandom);
      ev_data = w; ev_valid = 1'b1;
      checks++; if (ev_ready !== (model_q.size() < DEPTH)) begin
        errors++; $display("FAIL full_ready[%0d] got %b want %b", i, ev_ready, model_q.size() < DEPTH); end
      if (model_q.size() < DEPTH) model_q.push_back(w);
      @(negedge clk);
    end
    ev_valid = 1'b0;
    checks++; if (count !== 3'd4 || ev_ready !== 1'b0) begin
      errors++; $display("FAIL full_count got %0d/%b want 4/0", count, ev_ready); end
    run = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      observe(0, 0, 0, lat, len, a, d, st, to);
      checks++; if (to || a !== model_q[i][23:16] || d !== model_q[i][55:24]) begin
        errors++; $display("FAIL full_drain[%0d] got %h/%h want %h/%h", i, a, d,
                           model_q[i][23:16], model_q[i][55:24]); end
    end
    repeat (6) @(negedge clk);
    checks++; if (count !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_dropped got count %0d busy %b want 0/0", count, busy); end
    run = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [55:0] e[$]; int lat, len; logic [7:0] a; logic [31:0] d; bit st, to;
    for (int full = 0; full < 2; full++) begin
      e.delete();
      for (int i = 0; i < (full ? 5 : 3); i++) e.push_back(mk(16'd0, 8'($urandom), $urandom));
      for (int i = 0; i < e.size() - 1; i++) push_event(e[i]);
      run = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pp_load[%0d] got %b want 1", full, busy); end
      ev_data = e[e.size() - 1]; ev_valid = 1'b1;
      checks++; if (ev_ready !== (full == 0)) begin
        errors++; $display("FAIL pp_ready[%0d] got %b want %b", full, ev_ready, full == 0); end
      @(negedge clk);
      ev_valid = 1'b0;
      checks++; if (count !== (full ? 3'd3 : 3'd2)) begin
        errors++; $display("FAIL pp_count[%0d] got %0d want %0d", full, count, full ? 3 : 2); end
      if (full) e.delete(4);
      for (int i = 0; i < e.size(); i++) begin
        observe(0, 0, 0, lat, len, a, d, st, to);
        checks++; if (to || a !== e[i][23:16] || d !== e[i][55:24]) begin
          errors++; $display("FAIL pp_order[%0d.%0d] got %h want %h", full, i, a, e[i][23:16]); end
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL pp_empty got %0d want 0", count); end
      run = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [55:0] w; int n, dl, ack, pa, pl, lat, len, exp_lat, exp_len;
    logic [7:0] a; logic [31:0] d; bit st, to;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 3);
      model_q.delete();
      for (int i = 0; i < n; i++) begin
        w = mk(16'($urandom_range(0, 3)), 8'($urandom), $urandom);
        model_q.push_back(w);
        push_event(w);
      end
      checks++; if (count !== 3'(n)) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, n); end
      run = 1'b1;
      for (int i = 0; i < n; i++) begin
        dl = int'(model_q[i][15:0]);
        ack = $urandom_range(0, 9);
        pa = 0; pl = 0;
        if (dl > 0 && $urandom_range(0, 1) == 1) begin
          pa = $urandom_range(1, dl * TICK - 1); pl = $urandom_range(1, 6);
        end
        observe(ack, pa, pl, lat, len, a, d, st, to);
        exp_lat = (dl == 0) ? 1 : dl * TICK + pl;
        exp_len = (ack < TO) ? ack + 1 : TO;
        if (ack >= TO) err_exp = 1'b1;
        checks++; if (to || lat != exp_lat || len != exp_len) begin
          errors++; $display("FAIL rnd_timing[%0d.%0d] got lat %0d len %0d want %0d %0d",
                             b, i, lat, len, exp_lat, exp_len); end
        checks++; if (a !== model_q[i][23:16] || d !== model_q[i][55:24] || !st) begin
          errors++; $display("FAIL rnd_bus[%0d.%0d] got %h/%h want %h/%h", b, i, a, d,
                             model_q[i][23:16], model_q[i][55:24]); end
        checks++; if (err_timeout !== err_exp) begin
          errors++; $display("FAIL rnd_err[%0d.%0d] got %b want %b", b, i, err_timeout, err_exp); end
      end
      run = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int lat, len; logic [7:0] a; logic [31:0] d; bit st, to;
    push_event(mk(16'd1, 8'h5A, 32'hDEAD_0001));
    push_event(mk(16'd0, 8'h5B, 32'hDEAD_0002));
    run = 1'b1;
    observe(TO + 5, 0, 0, lat, len, a, d, st, to);
    err_exp = 1'b1;
    checks++; if (to || len != TO) begin errors++; $display("FAIL to_len got %0d want %0d", len, TO); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err_timeout); end
    observe(0, 0, 0, lat, len, a, d, st, to);
    checks++; if (to || a !== 8'h5B || lat != 1 || len != 1) begin
      errors++; $display("FAIL to_next got %h lat %0d len %0d want 5b 1 1", a, lat, len); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", err_timeout); end
    run = 1'b0;
  endtask

  task automatic test_pause();
    int lat, len; logic [7:0] a; logic [31:0] d; bit st, to;
    push_event(mk(16'd10, 8'h77, 32'h1234_5678));
    run = 1'b1;
    observe(0, 2 * TICK + 1, 20, lat, len, a, d, st, to);
    checks++; if (to || lat != 10 * TICK + 20) begin
      errors++; $display("FAIL pause_lat got %0d want %0d", lat, 10 * TICK + 20); end
    run = 1'b0;
  endtask

  task automatic test_flush();
    int n; bit seen;
    for (int i = 0; i < 3; i++) push_event(mk(16'd5, 8'(8'h40 + i), $urandom));
    run = 1'b1; n = 0;
    while (!busy && n < BUDGET) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (count !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_wait got count %0d busy %b want 0/0", count, busy); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (m_wen) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_write got strobe want none"); end
    run = 1'b0;
    for (int i = 0; i < 3; i++) push_event(mk(16'd0, 8'(8'h50 + i), $urandom));
    run = 1'b1; n = 0;
    while (!m_wen && n < BUDGET) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (m_wen !== 1'b1 || m_addr !== 8'h50 || count !== 3'd0) begin
      errors++; $display("FAIL flush_write got wen %b addr %h count %0d want 1 50 0", m_wen, m_addr, count); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (m_wen !== 1'b0 || err_timeout !== err_exp) begin
      errors++; $display("FAIL flush_complete got wen %b err %b want 0 %b", m_wen, err_timeout, err_exp); end
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %b want 0", busy); end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int n;
    push_event(mk(16'd0, 8'h66, 32'hCAFE_F00D));
    push_event(mk(16'd2, 8'h67, 32'hCAFE_F00E));
    run = 1'b1; n = 0;
    while (!m_wen && n < BUDGET) begin @(negedge clk); n++; end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({m_wen, busy, err_timeout, count} !== 6'd0) begin
      errors++; $display("FAIL mid_reset got %b want 0", {m_wen, busy, err_timeout, count}); end
    rst = 1'b1; run = 1'b0; err_exp = 1'b0;
    @(negedge clk);
  endtask

`ifdef SYNTH_SEQUENCER_LOOP_EN
  task automatic test_loop();
    int lat, len; logic [7:0] a; logic [31:0] d; bit st, to;
    push_event(mk(16'd0, 8'hA1, 32'hAAAA_0001));
    push_event(mk(16'd1, 8'hB2, 32'hBBBB_0002));
    loop = 1'b1; run = 1'b1;
    #1;
    checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL loop_ready got %b want 0", ev_ready); end
    for (int i = 0; i < 4; i++) begin
      observe(0, 0, 0, lat, len, a, d, st, to);
      checks++; if (to || a !== ((i % 2 == 0) ? 8'hA1 : 8'hB2) || count !== 3'd2) begin
        errors++; $display("FAIL loop_seq[%0d] got %h count %0d", i, a, count); end
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    loop = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_push_pop();
    test_random();
    test_timeout();
    test_pause();
    test_flush();
    test_reset_mid_write();
`ifdef SYNTH_SEQUENCER_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
